// File: rtl/opfetch_pkg.sv
// Opcode constants and instruction decode helpers shared by the operand fetch stage.
package opfetch_pkg;

  localparam int NUM_REGS = 32;

  localparam logic [5:0] OP_RTYPE       = 6'h00;
  localparam logic [5:0] OP_J           = 6'h02;
  localparam logic [5:0] OP_JAL         = 6'h03;
  localparam logic [5:0] OP_BEQ         = 6'h04;
  localparam logic [5:0] OP_BNE         = 6'h05;
  localparam logic [5:0] OP_LUI         = 6'h0F;
  localparam logic [5:0] OP_ALUI_FIRST  = 6'h08;
  localparam logic [5:0] OP_ALUI_LAST   = 6'h0F;
  localparam logic [5:0] OP_ZEXT_FIRST  = 6'h0C;
  localparam logic [5:0] OP_ZEXT_LAST   = 6'h0E;
  localparam logic [5:0] OP_LOAD_FIRST  = 6'h20;
  localparam logic [5:0] OP_LOAD_LAST   = 6'h25;
  localparam logic [5:0] OP_STORE_FIRST = 6'h28;
  localparam logic [5:0] OP_STORE_LAST  = 6'h2B;

  localparam logic [4:0] REG_RA = 5'd31;

  // Returns 0 when the instruction writes no register (a $0 target is treated the same way).
  function automatic logic [4:0] dest_of(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[31:26];
    if (op == OP_RTYPE) return instr[15:11];
    if ((op >= OP_ALUI_FIRST && op <= OP_ALUI_LAST) ||
        (op >= OP_LOAD_FIRST && op <= OP_LOAD_LAST)) return instr[20:16];
    if (op == OP_JAL) return REG_RA;
    return 5'd0;
  endfunction

  function automatic logic uses_rs(input logic [5:0] op);
    return !(op == OP_J || op == OP_JAL || op == OP_LUI);
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op >= OP_STORE_FIRST && op <= OP_STORE_LAST);
  endfunction

  function automatic logic imm_zext(input logic [5:0] op);
    return (op >= OP_ZEXT_FIRST) && (op <= OP_ZEXT_LAST);
  endfunction

endpackage

// File: rtl/opfetch_scoreboard.sv
// Pending-write bitmap for the 32 architectural registers plus the issue hazard check.
module opfetch_scoreboard
  import opfetch_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [4:0]          set_idx,
  input  logic                wb_valid,
  input  logic [4:0]          wb_reg,
  input  logic                flush_clr,
  input  logic [4:0]          flush_idx,
  input  logic                byp_valid,
  input  logic [4:0]          byp_reg,
  input  logic                chk_a_en,
  input  logic [4:0]          chk_a,
  input  logic                chk_b_en,
  input  logic [4:0]          chk_b,
  input  logic [4:0]          chk_d,
  output logic [NUM_REGS-1:0] pending,
  output logic                hazard
);

  logic [NUM_REGS-1:0] pending_d, pending_q, visible;

  // Clears are applied first so a set on the same bit in the same cycle wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid)  pending_d[wb_reg]    = 1'b0;
    if (flush_clr) pending_d[flush_idx] = 1'b0;
    if (set_en)    pending_d[set_idx]   = 1'b1;
    pending_d[0] = 1'b0;
  end

  // A register being written back this cycle may be hidden from the hazard check.
  always_comb begin
    visible = pending_q;
    if (byp_valid) visible[byp_reg] = 1'b0;
    hazard = (chk_a_en && visible[chk_a]) || (chk_b_en && visible[chk_b]) || visible[chk_d];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/operand_fetch.sv
// Issue stage ahead of the register file: decodes sources/destination, stalls on pending writes.
// Define OPFETCH_BYPASS_EN to let a dependent instruction issue in its source's writeback cycle.
module operand_fetch
  import opfetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inValid,
  output logic            inReady,
  input  logic [XLEN-1:0] inInstr,
  output logic [4:0]      srcRegA,
  output logic [4:0]      srcRegB,
  input  logic [XLEN-1:0] outBusA,
  input  logic [XLEN-1:0] outBusB,
  input  logic            wbValid,
  input  logic [4:0]      wbReg,
  input  logic [XLEN-1:0] wbData,
  input  logic            flush,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] outOpA,
  output logic [XLEN-1:0] outOpB,
  output logic [XLEN-1:0] outImm,
  output logic [4:0]      outDest,
  output logic [5:0]      outOpcode,
  output logic [5:0]      outFunct
);

  logic [5:0]          in_op;
  logic [4:0]          in_dest;
  logic                use_a, use_b;
  logic [XLEN-1:0]     in_imm, op_a, op_b;
  logic                byp_valid, fwd_a, fwd_b;
  logic                hazard, issue, flush_clr;
  logic [NUM_REGS-1:0] pending;

  logic            out_valid_d, out_valid_q;
  logic [XLEN-1:0] op_a_d, op_a_q, op_b_d, op_b_q, imm_d, imm_q;
  logic [4:0]      dest_d, dest_q;
  logic [5:0]      opcode_d, opcode_q, funct_d, funct_q;

  assign in_op   = inInstr[31:26];
  assign srcRegA = inInstr[25:21];
  assign srcRegB = inInstr[20:16];
  assign in_dest = dest_of(inInstr);
  assign use_a   = uses_rs(in_op);
  assign use_b   = uses_rt(in_op);
  assign in_imm  = imm_zext(in_op) ? {{(XLEN-16){1'b0}}, inInstr[15:0]}
                                   : {{(XLEN-16){inInstr[15]}}, inInstr[15:0]};

`ifdef OPFETCH_BYPASS_EN
  assign byp_valid = wbValid && (wbReg != 5'd0);
`else
  assign byp_valid = 1'b0;
`endif

  // Register file writes land at the edge, so a same-cycle match must take wbData directly.
  assign fwd_a = byp_valid && (wbReg == srcRegA);
  assign fwd_b = byp_valid && (wbReg == srcRegB);
  assign op_a  = !use_a ? '0 : (fwd_a ? wbData : outBusA);
  assign op_b  = !use_b ? '0 : (fwd_b ? wbData : outBusB);

  assign inReady   = reset && !hazard && (!out_valid_q || outReady) && !flush;
  assign issue     = inValid && inReady;
  assign flush_clr = flush && out_valid_q;

  opfetch_scoreboard u_sb (
    .clk       (clk),
    .reset     (reset),
    .set_en    (issue),
    .set_idx   (in_dest),
    .wb_valid  (wbValid),
    .wb_reg    (wbReg),
    .flush_clr (flush_clr),
    .flush_idx (dest_q),
    .byp_valid (byp_valid),
    .byp_reg   (wbReg),
    .chk_a_en  (use_a),
    .chk_a     (srcRegA),
    .chk_b_en  (use_b),
    .chk_b     (srcRegB),
    .chk_d     (in_dest),
    .pending   (pending),
    .hazard    (hazard)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    imm_d       = imm_q;
    dest_d      = dest_q;
    opcode_d    = opcode_q;
    funct_d     = funct_q;
    if (flush)         out_valid_d = 1'b0;
    else if (issue)    out_valid_d = 1'b1;
    else if (outReady) out_valid_d = 1'b0;
    if (issue) begin
      op_a_d   = op_a;
      op_b_d   = op_b;
      imm_d    = in_imm;
      dest_d   = in_dest;
      opcode_d = in_op;
      funct_d  = inInstr[5:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      imm_q       <= '0;
      dest_q      <= '0;
      opcode_q    <= '0;
      funct_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      imm_q       <= imm_d;
      dest_q      <= dest_d;
      opcode_q    <= opcode_d;
      funct_q     <= funct_d;
    end
  end

  assign outValid  = out_valid_q;
  assign outOpA    = op_a_q;
  assign outOpB    = op_b_q;
  assign outImm    = imm_q;
  assign outDest   = dest_q;
  assign outOpcode = opcode_q;
  assign outFunct  = funct_q;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Issue stage directly upstream of `registerFile`:
- Accepts 32-bit MIPS instruction words from fetch over a valid/ready handshake.
- Drives the register file read addresses and captures the operands into a pipeline register for execute.
- Keeps a 32-entry pending-write scoreboard, so no instruction issues while a source or destination register still awaits writeback.

## Interface
Parameters:
- `XLEN`, 32, datapath and instruction width.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `inValid` input 1: instruction word valid.
- `inReady` output 1: stage accepts `inInstr` this cycle.
- `inInstr` input 32: instruction word.
- `srcRegA` output 5: read address A to register file (= instr[25:21]).
- `srcRegB` output 5: read address B to register file (= instr[20:16]).
- `outBusA` input 32: register file read data A (combinational).
- `outBusB` input 32: register file read data B (combinational).
- `wbValid` input 1: writeback occurring this cycle (same signal as register file `regWrite`).
- `wbReg` input 5: writeback destination.
- `wbData` input 32: writeback data.
- `flush` input 1: kill the instruction held in the output register.
- `outValid` output 1: issued instruction valid.
- `outReady` input 1: execute accepts.
- `outOpA` output 32: operand A.
- `outOpB` output 32: operand B.
- `outImm` output 32: sign-extended instr[15:0] (zero-extended for opcodes 0x0C–0x0E).
- `outDest` output 5: destination register; 0 if none.
- `outOpcode` output 6: instr[31:26].
- `outFunct` output 6: instr[5:0].

## Operation
- Destination decode:
  - opcode 0x00 → rd.
  - 0x08–0x0F and 0x20–0x25 → rt.
  - 0x03 (jal) → 31.
  - All others → none.
  - A destination of $0 counts as none.
- Source use:
  - A (rs) is used by all opcodes except 0x02, 0x03 and 0x0F.
  - B (rt) is used by opcode 0x00, 0x04, 0x05 and 0x28–0x2B.
  - Register 0 is never pending.
- Scoreboard: 32-bit `pending` bitmap.
  - Set bit[dest] on issue.
  - Clear bit[wbReg] when `wbValid`.
  - On the same bit in the same cycle, set wins over clear.
- Hazard: a used source, or the destination, has its pending bit set (the destination check forbids WAW).
- Issue condition: `inReady = !hazard && (!outValid || outReady)`. Issue = `inValid && inReady`; it loads all `out*` fields and sets `outValid`.
- Drain: `outValid && outReady` without a new issue clears `outValid`.
- Operand selection: the used operand takes `outBusA`/`outBusB`. An unused operand is captured as 0.
- Flush:
  - Clears `outValid` next edge.
  - Clears the pending bit of the flushed instruction's `outDest`.
  - Blocks issue in the flush cycle (`inReady` = 0).
- Reset: `pending` = 0 and `outValid` = 0. Every `out*` data field is 0. `inReady` is 1 once reset deasserts.

## Timing
- Latency: 1 cycle from accepted instruction to `outValid`.
- Throughput: 1 instruction per cycle absent hazards.
- `srcRegA`/`srcRegB` are combinational from `inInstr`. Held upstream under backpressure.
- Register file writes land at the clock edge, so same-cycle reads return the old value. Behaviour in that cycle depends on `OPFETCH_BYPASS_EN` (see Configuration).
- Full pending map: issue continues for instructions whose registers are all clear.
- Reset mid-stream: asynchronous. It drops the held instruction and the scoreboard immediately. Writebacks arriving after reset are ignored by the cleared map.

## Configuration
- `OPFETCH_BYPASS_EN` defined:
  - A same-cycle `wbValid && wbReg == r` (r ≠ 0) treats r as not pending for the hazard check.
  - A source matching `wbReg` captures `wbData` instead of `outBus*`.
  - The dependent instruction issues in the writeback cycle.
- Undefined:
  - Hazard uses registered `pending` only.
  - The dependent instruction issues the cycle after writeback and reads the register file.
  - This adds 1 cycle per RAW dependence.

## Structure
- Shared package `opfetch_pkg`: opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LUI, load/store/ALU-imm ranges) and destination/source-use decode functions.
- Sub-module `opfetch_scoreboard`:
  - Inputs: set enable/index, writeback clear, flush clear, bypass qualification.
  - Outputs: the pending bitmap and the hazard signal.

## Test plan
- Reset, then `addi $5,$0,7` with `outReady`=1. Required: `outValid` next cycle, `outDest`=5, `outImm`=7, `pending[5]`=1.
- Back-to-back `add $3,$1,$2` then `sub $4,$3,$1`, writeback of $3=0x10 three cycles later:
  - Second instruction stalls (`inReady`=0) until writeback.
  - With bypass: issues in the writeback cycle with `outOpA`=0x10.
  - Without bypass: issues one cycle later, same operand.
- `outReady`=0 for 4 cycles with `outValid`=1 → `out*` fields stable, `inReady`=0, no issue lost or duplicated.
- Flush while holding `lw $8,0($9)` → `outValid`=0 next cycle, `pending[8]`=0, a following `add $1,$8,$8` issues without writeback.
- `addu $0,$1,$2` followed by `or $6,$0,$0` → no stall, `outDest`=0, `pending`=0.
- Assert reset while `pending[7]`=1 and `outValid`=1 → all outputs 0 immediately. A later `wbValid` to $7 causes no effect.
